// File: rtl/fsmc_pkg.sv
// fsmc_pkg: shared definitions for the FSMC asynchronous SRAM/PSRAM sequencer.
//   - FSMC_AW / FSMC_DW : default external address / data widths
//   - DOEN_DRIVE / DOEN_HIZ : per-bit output-enable levels (active-low)
//   - state_e : sequencer state encoding
//   - lowest_bank() : one-hot of the lowest set bank-select bit
package fsmc_pkg;

  localparam int FSMC_AW = 26;
  localparam int FSMC_DW = 16;

  localparam logic [15:0] DOEN_DRIVE = 16'h0000;
  localparam logic [15:0] DOEN_HIZ   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_TURN = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  // Priority pick: bit 0 wins over bit 1 and so on; all-zero yields zero.
  function automatic logic [3:0] lowest_bank(input logic [3:0] sel);
    logic [3:0] r;
    r = 4'b0000;
    if (sel[0])      r = 4'b0001;
    else if (sel[1]) r = 4'b0010;
    else if (sel[2]) r = 4'b0100;
    else if (sel[3]) r = 4'b1000;
    return r;
  endfunction

endpackage

// File: rtl/fsmc_phase_cnt.sv
// fsmc_phase_cnt: 8-bit loadable down-counter timing the ADDR, DATA and TURN
// phases of the sequencer.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   load_i     : load load_val_i (takes priority over hold/decrement)
//   hold_i     : freeze the count
//   load_val_i : value to load (phase length minus 1)
//   zero_o     : count has reached zero (last cycle of the phase)
module fsmc_phase_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       hold_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (!hold_i && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/fsmc_sram_seq.sv
// fsmc_sram_seq: asynchronous SRAM/PSRAM bus-cycle sequencer (mode 1 style).
// Accepts one request when idle, latches it together with the bank timing,
// then walks ADDR -> DATA (-> TURN) per 16-bit half. Word accesses run two
// halves, low half first, with the address incremented for the high half.
//   hclk/hresetn        : clock, synchronous active-low reset
//   req*/bank_sel       : request fields, sampled only at the accept edge
//   addset/datast/busturn/waiten : phase timing, sampled at the accept edge
//   fsmc_nwait/fsmc_di  : external wait and read data
//   busy/ack/err/rdata  : status and completion (err/rdata valid with ack)
//   fsmc_*              : external bus pins (all registered)
//   dbg_state           : current sequencer state
//
// Request handshake: req is a valid-style strobe taken on any edge where
// busy is low; there is no separate ready, busy=0 is the ready condition.
module fsmc_sram_seq
  import fsmc_pkg::*;
#(
  parameter int AW = FSMC_AW,
  parameter int DW = FSMC_DW
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          req,
  input  logic          req_write,
  input  logic          req_word,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [1:0]    req_nbl,
  input  logic [3:0]    bank_sel,
  input  logic [3:0]    addset,
  input  logic [7:0]    datast,
  input  logic [3:0]    busturn,
  input  logic          waiten,
  input  logic          fsmc_nwait,
  input  logic [DW-1:0] fsmc_di,
  output logic          busy,
  output logic          ack,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] fsmc_a,
  output logic [DW-1:0] fsmc_do,
  output logic [DW-1:0] fsmc_doen,
  output logic          fsmc_noe,
  output logic          fsmc_nwe,
  output logic [3:0]    fsmc_ne,
  output logic [1:0]    fsmc_nbl,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic          write_q, write_d, word_q, word_d, waiten_q, waiten_d;
  logic          half_q, half_d, fin_q, fin_d;
  logic [1:0]    nbl_q, nbl_d;
  logic [3:0]    bank_q, bank_d, addset_q, addset_d, busturn_q, busturn_d;
  logic [7:0]    datast_q, datast_d;
  logic [DW-1:0] wdata_hi_q, wdata_hi_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] do_q, do_d, doen_q, doen_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d, err_q, err_d, noe_q, noe_d, nwe_q, nwe_d;
  logic [3:0]    ne_q, ne_d;
  logic [1:0]    nblo_q, nblo_d;
  logic          cnt_load, cnt_hold, cnt_zero, last_half, active;
  logic [7:0]    cnt_val;

  fsmc_phase_cnt u_cnt (
    .clk_i      (hclk),
    .rst_ni     (hresetn),
    .load_i     (cnt_load),
    .hold_i     (cnt_hold),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign last_half = !word_q || half_q;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    word_d     = word_q;
    waiten_d   = waiten_q;
    half_d     = half_q;
    fin_d      = fin_q;
    nbl_d      = nbl_q;
    bank_d     = bank_q;
    addset_d   = addset_q;
    busturn_d  = busturn_q;
    datast_d   = datast_q;
    wdata_hi_d = wdata_hi_q;
    a_d        = a_q;
    do_d       = do_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_hold   = 1'b0;
    cnt_val    = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          write_d    = req_write;
          word_d     = req_word;
          waiten_d   = waiten;
          half_d     = 1'b0;
          fin_d      = 1'b0;
          nbl_d      = req_word ? 2'b00 : req_nbl;
          bank_d     = lowest_bank(bank_sel);
          addset_d   = addset;
          busturn_d  = busturn;
          datast_d   = datast;
          wdata_hi_d = req_wdata[31:16];
          a_d        = req_addr;
          if (req_write) do_d = req_wdata[15:0];
          if (bank_sel == 4'b0000) begin
            state_d = S_ERR;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = S_ADDR;
            cnt_load = 1'b1;
            cnt_val  = {4'b0000, addset};
          end
        end
      end
      S_ADDR: begin
        if (cnt_zero) begin
          state_d  = S_DATA;
          cnt_load = 1'b1;
          cnt_val  = datast_q;
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          if (waiten_q && !fsmc_nwait) begin
            cnt_hold = 1'b1;
          end else begin
            if (!write_q) begin
              if (!word_q)     rdata_d = {16'h0000, fsmc_di};
              else if (!half_q) rdata_d = {rdata_q[31:16], fsmc_di};
              else             rdata_d = {fsmc_di, rdata_q[15:0]};
            end
            if (!last_half) begin
              half_d = 1'b1;
              a_d    = a_q + AW'(1);
              if (write_q) do_d = wdata_hi_q;
            end else begin
              ack_d = 1'b1;
              fin_d = 1'b1;
            end
            cnt_load = 1'b1;
            if (busturn_q != 4'd0) begin
              state_d = S_TURN;
              cnt_val = {4'b0000, busturn_q - 4'd1};
            end else if (!last_half) begin
              state_d = S_ADDR;
              cnt_val = {4'b0000, addset_q};
            end else begin
              state_d  = S_IDLE;
              cnt_load = 1'b0;
            end
          end
        end
      end
      S_TURN: begin
        if (cnt_zero) begin
          if (fin_q) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_ADDR;
            cnt_load = 1'b1;
            cnt_val  = {4'b0000, addset_q};
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin levels follow the state being entered so every pin is a flop.
    active = (state_d == S_ADDR) || (state_d == S_DATA);
    ne_d   = active ? ~bank_d : 4'hF;
    nblo_d = active ? nbl_d : 2'b11;
    doen_d = (active && write_d) ? DOEN_DRIVE : DOEN_HIZ;
    noe_d  = !((state_d == S_DATA) && !write_d);
    nwe_d  = !((state_d == S_DATA) && write_d);
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      word_q     <= 1'b0;
      waiten_q   <= 1'b0;
      half_q     <= 1'b0;
      fin_q      <= 1'b0;
      nbl_q      <= 2'b11;
      bank_q     <= 4'b0000;
      addset_q   <= 4'd0;
      busturn_q  <= 4'd0;
      datast_q   <= 8'd0;
      wdata_hi_q <= '0;
      a_q        <= '0;
      do_q       <= '0;
      doen_q     <= DOEN_HIZ;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      ne_q       <= 4'hF;
      nblo_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      word_q     <= word_d;
      waiten_q   <= waiten_d;
      half_q     <= half_d;
      fin_q      <= fin_d;
      nbl_q      <= nbl_d;
      bank_q     <= bank_d;
      addset_q   <= addset_d;
      busturn_q  <= busturn_d;
      datast_q   <= datast_d;
      wdata_hi_q <= wdata_hi_d;
      a_q        <= a_d;
      do_q       <= do_d;
      doen_q     <= doen_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      noe_q      <= noe_d;
      nwe_q      <= nwe_d;
      ne_q       <= ne_d;
      nblo_q     <= nblo_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign fsmc_a    = a_q;
  assign fsmc_do   = do_q;
  assign fsmc_doen = doen_q;
  assign fsmc_noe  = noe_q;
  assign fsmc_nwe  = nwe_q;
  assign fsmc_ne   = ne_q;
  assign fsmc_nbl  = nblo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fsmc_sram_seq.sv
module tb_fsmc_sram_seq;
  import fsmc_pkg::*;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic        req = 0, req_write = 0, req_word = 0, waiten = 0, fsmc_nwait = 1;
  logic [25:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_nbl = 2'b11;
  logic [3:0]  bank_sel = '0, addset = '0, busturn = '0;
  logic [7:0]  datast = '0;
  logic [15:0] fsmc_di;
  logic        busy, ack, err, fsmc_noe, fsmc_nwe;
  logic [31:0] rdata;
  logic [25:0] fsmc_a;
  logic [15:0] fsmc_do, fsmc_doen;
  logic [3:0]  fsmc_ne;
  logic [1:0]  fsmc_nbl;
  state_e      dbg_state;

  // external memory model: first halfword address returns di0, any other di1
  logic [25:0] cur_addr = '0;
  logic [15:0] cur_di0 = '0, cur_di1 = '0;
  assign fsmc_di = (fsmc_a == cur_addr) ? cur_di0 : cur_di1;

  fsmc_sram_seq dut (
    .hclk(hclk), .hresetn(hresetn), .req(req), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_nbl(req_nbl), .bank_sel(bank_sel), .addset(addset), .datast(datast),
    .busturn(busturn), .waiten(waiten), .fsmc_nwait(fsmc_nwait),
    .fsmc_di(fsmc_di), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .fsmc_a(fsmc_a), .fsmc_do(fsmc_do), .fsmc_doen(fsmc_doen),
    .fsmc_noe(fsmc_noe), .fsmc_nwe(fsmc_nwe), .fsmc_ne(fsmc_ne),
    .fsmc_nbl(fsmc_nbl), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input int idx, input logic [31:0] got);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic wr, word, wen;
    logic [25:0] addr; logic [31:0] wdata; logic [1:0] nbl;
    logic [3:0] bank, a, t; logic [7:0] d;
    logic [15:0] di0, di1;
    int wait_start, wait_len;
    int exp_ack, exp_idle, exp_ne_cnt, exp_noe_cnt, exp_nwe_cnt;
    logic [3:0] exp_ne; logic [1:0] exp_nbl;
    logic [25:0] exp_a_first, exp_a_last;
    logic [15:0] exp_doen, exp_do_first, exp_do_last;
    logic [31:0] exp_rdata; logic exp_err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int ack_cyc = 0, ack_cnt = 0, idle_cyc = 0, ne_cnt = 0, noe_cnt = 0, nwe_cnt = 0;
    logic [3:0] ne_seen = 4'hF, ne_at_ack = 4'h0;
    logic [1:0] nbl_seen = 2'b11;
    logic [25:0] a_first = '0, a_last = '0;
    logic [15:0] doen_seen = '0, do_first = '0, do_last = '0;
    logic [31:0] rd_at_ack = '0;
    logic err_at_ack = 1'b0, done = 1'b0;

    @(negedge hclk);
    cur_addr = v.addr; cur_di0 = v.di0; cur_di1 = v.di1;
    req = 1; req_write = v.wr; req_word = v.word; req_addr = v.addr;
    req_wdata = v.wdata; req_nbl = v.nbl; bank_sel = v.bank;
    addset = v.a; datast = v.d; busturn = v.t; waiten = v.wen; fsmc_nwait = 1;
    @(posedge hclk); #1;
    // scramble everything after accept: the access must run on latched values
    req = 0; req_write = ~v.wr; req_word = ~v.word; req_addr = 26'h2AAAAAA;
    req_wdata = 32'hDEADDEAD; bank_sel = 4'hF; addset = 4'hF; datast = 8'hFF;
    busturn = 4'hF; waiten = ~v.wen;

    for (int k = 1; k <= 100 && !done; k++) begin
      fsmc_nwait = !(k >= v.wait_start && k < v.wait_start + v.wait_len);
      @(negedge hclk);
      if (fsmc_ne != 4'hF) begin
        if (ne_cnt == 0) begin
          ne_seen = fsmc_ne; nbl_seen = fsmc_nbl; a_first = fsmc_a; doen_seen = fsmc_doen;
        end
        ne_cnt++; a_last = fsmc_a;
      end
      if (!fsmc_noe) noe_cnt++;
      if (!fsmc_nwe) begin
        if (nwe_cnt == 0) do_first = fsmc_do;
        nwe_cnt++; do_last = fsmc_do;
      end
      if (ack) begin
        ack_cnt++; ack_cyc = k; rd_at_ack = rdata; err_at_ack = err; ne_at_ack = fsmc_ne;
      end
      if (ack_cnt > 0 && !busy) begin idle_cyc = k; done = 1'b1; end
      @(posedge hclk); #1;
    end
    fsmc_nwait = 1;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout[%0d] no ack/idle within 100 cycles", idx);
    end

    exp_q.push_back(v.exp_ack);     chk("ack_cycle", idx, ack_cyc);
    exp_q.push_back(1);             chk("ack_pulses", idx, ack_cnt);
    exp_q.push_back(v.exp_idle);    chk("idle_cycle", idx, idle_cyc);
    exp_q.push_back(v.exp_err);     chk("err", idx, {31'b0, err_at_ack});
    exp_q.push_back(v.exp_ne_cnt);  chk("ne_low_cycles", idx, ne_cnt);
    exp_q.push_back(v.exp_noe_cnt); chk("noe_low_cycles", idx, noe_cnt);
    exp_q.push_back(v.exp_nwe_cnt); chk("nwe_low_cycles", idx, nwe_cnt);
    exp_q.push_back(32'hF);         chk("ne_in_ack_cycle", idx, {28'b0, ne_at_ack});
    if (v.exp_ne_cnt > 0) begin
      exp_q.push_back(v.exp_ne);      chk("ne_value", idx, {28'b0, ne_seen});
      exp_q.push_back(v.exp_nbl);     chk("nbl_value", idx, {30'b0, nbl_seen});
      exp_q.push_back(v.exp_a_first); chk("addr_first", idx, {6'b0, a_first});
      exp_q.push_back(v.exp_a_last);  chk("addr_last", idx, {6'b0, a_last});
      exp_q.push_back(v.exp_doen);    chk("doen", idx, {16'b0, doen_seen});
    end
    if (v.wr) begin
      exp_q.push_back(v.exp_do_first); chk("do_first", idx, {16'b0, do_first});
      exp_q.push_back(v.exp_do_last);  chk("do_last", idx, {16'b0, do_last});
    end else if (!v.exp_err) begin
      exp_q.push_back(v.exp_rdata);    chk("rdata", idx, rd_at_ack);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //         wr word wen addr          wdata          nbl    bank     a     t     d     di0       di1     ws wl ack idle ne noe nwe exp_ne   nbl    a_first        a_last         doen      do1       do2       rdata          err
    vecs[0] = '{1, 0, 0, 26'h0000123, 32'h0000BEEF, 2'b10, 4'b0010, 4'd2, 4'd0, 8'd3, 16'h0,    16'h0,    0, 0, 8,  8, 7,  0,  4, 4'b1101, 2'b10, 26'h0000123, 26'h0000123, 16'h0000, 16'hBEEF, 16'hBEEF, 32'h0,        1'b0};
    vecs[1] = '{0, 1, 0, 26'h0000010, 32'h0,        2'b11, 4'b0001, 4'd0, 4'd2, 8'd1, 16'h1111, 16'h2222, 0, 0, 9, 11, 6,  4,  0, 4'b1110, 2'b00, 26'h0000010, 26'h0000011, 16'hFFFF, 16'h0,    16'h0,    32'h22221111, 1'b0};
    vecs[2] = '{0, 0, 0, 26'h00003FF, 32'h0,        2'b01, 4'b1100, 4'd1, 4'd0, 8'd0, 16'hA5A5, 16'h0,    0, 0, 4,  4, 3,  1,  0, 4'b1011, 2'b01, 26'h00003FF, 26'h00003FF, 16'hFFFF, 16'h0,    16'h0,    32'h0000A5A5, 1'b0};
    vecs[3] = '{1, 1, 0, 26'h3FFFFFF, 32'hCAFE1234, 2'b11, 4'b1000, 4'd1, 4'd0, 8'd2, 16'h0,    16'h0,    0, 0, 11, 11, 10, 0,  6, 4'b0111, 2'b00, 26'h3FFFFFF, 26'h0000000, 16'h0000, 16'h1234, 16'hCAFE, 32'h0,        1'b0};
    vecs[4] = '{0, 0, 0, 26'h0000099, 32'h0,        2'b11, 4'b0000, 4'd3, 4'd2, 8'd4, 16'h0,    16'h0,    0, 0, 1,  2, 0,  0,  0, 4'hF,    2'b11, 26'h0,        26'h0,        16'hFFFF, 16'h0,    16'h0,    32'h0,        1'b1};
    vecs[5] = '{0, 0, 0, 26'h0000055, 32'h0,        2'b00, 4'b0100, 4'd0, 4'd3, 8'd0, 16'h0F0F, 16'h0,    0, 0, 3,  6, 2,  1,  0, 4'b1011, 2'b00, 26'h0000055, 26'h0000055, 16'hFFFF, 16'h0,    16'h0,    32'h00000F0F, 1'b0};
    vecs[6] = '{0, 0, 1, 26'h0000040, 32'h0,        2'b00, 4'b0001, 4'd1, 4'd0, 8'd2, 16'h7E57, 16'h0,    5, 5, 11, 11, 10, 8,  0, 4'b1110, 2'b00, 26'h0000040, 26'h0000040, 16'hFFFF, 16'h0,    16'h0,    32'h00007E57, 1'b0};
    vecs[7] = '{0, 0, 0, 26'h0000040, 32'h0,        2'b00, 4'b0001, 4'd1, 4'd0, 8'd2, 16'h7E57, 16'h0,    5, 5, 6,  6, 5,  3,  0, 4'b1110, 2'b00, 26'h0000040, 26'h0000040, 16'hFFFF, 16'h0,    16'h0,    32'h00007E57, 1'b0};

    // reset state
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    exp_q.push_back(0);       chk("rst_busy", 0, {31'b0, busy});
    exp_q.push_back(0);       chk("rst_ack", 0, {31'b0, ack});
    exp_q.push_back(0);       chk("rst_err", 0, {31'b0, err});
    exp_q.push_back(0);       chk("rst_rdata", 0, rdata);
    exp_q.push_back(0);       chk("rst_a", 0, {6'b0, fsmc_a});
    exp_q.push_back(0);       chk("rst_do", 0, {16'b0, fsmc_do});
    exp_q.push_back(32'hFFFF); chk("rst_doen", 0, {16'b0, fsmc_doen});
    exp_q.push_back(32'h3);   chk("rst_noe_nwe", 0, {30'b0, fsmc_noe, fsmc_nwe});
    exp_q.push_back(32'hF);   chk("rst_ne", 0, {28'b0, fsmc_ne});
    exp_q.push_back(32'h3);   chk("rst_nbl", 0, {30'b0, fsmc_nbl});
    exp_q.push_back(S_IDLE);  chk("rst_state", 0, {29'b0, dbg_state});
    @(posedge hclk); #1 hresetn = 1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // back-to-back halfword reads, second accepted in the first's ack cycle
    begin
      logic ack_k[7]; logic busy_k[7]; logic [3:0] ne_k[7]; logic [25:0] a_k[7]; logic [31:0] rd_k[7];
      @(negedge hclk);
      cur_addr = 26'h20; cur_di0 = 16'hAAAA; cur_di1 = 16'hBBBB;
      req = 1; req_write = 0; req_word = 0; req_addr = 26'h20; req_nbl = 2'b00;
      bank_sel = 4'b0001; addset = 0; datast = 0; busturn = 0; waiten = 0;
      @(posedge hclk); #1 req_addr = 26'h21;
      for (int k = 1; k <= 6; k++) begin
        @(negedge hclk);
        ack_k[k] = ack; busy_k[k] = busy; ne_k[k] = fsmc_ne; a_k[k] = fsmc_a; rd_k[k] = rdata;
        @(posedge hclk); #1;
        if (k == 3) req = 0;
      end
      exp_q.push_back(1);            chk("b2b_ack1", 0, {31'b0, ack_k[3]});
      exp_q.push_back(0);            chk("b2b_busy_in_ack", 0, {31'b0, busy_k[3]});
      exp_q.push_back(32'h0000AAAA); chk("b2b_rdata1", 0, rd_k[3]);
      exp_q.push_back(32'hE);        chk("b2b_ne2", 0, {28'b0, ne_k[4]});
      exp_q.push_back(32'h21);       chk("b2b_addr2", 0, {6'b0, a_k[4]});
      exp_q.push_back(1);            chk("b2b_ack2", 0, {31'b0, ack_k[6]});
      exp_q.push_back(32'h0000BBBB); chk("b2b_rdata2", 0, rd_k[6]);
    end

    // reset during the DATA phase of a halfword write
    begin
      int acks = 0;
      @(negedge hclk);
      req = 1; req_write = 1; req_word = 0; req_addr = 26'h77; req_wdata = 32'h5A5A;
      req_nbl = 2'b00; bank_sel = 4'b0001; addset = 1; datast = 3; busturn = 0; waiten = 0;
      @(posedge hclk); #1 req = 0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      exp_q.push_back(0); chk("rst_mid_nwe_before", 0, {31'b0, fsmc_nwe});
      hresetn = 0;
      @(posedge hclk); #1 hresetn = 1;
      @(negedge hclk);
      exp_q.push_back(0);        chk("rst_mid_busy", 0, {31'b0, busy});
      exp_q.push_back(32'hF);    chk("rst_mid_ne", 0, {28'b0, fsmc_ne});
      exp_q.push_back(32'h3);    chk("rst_mid_noe_nwe", 0, {30'b0, fsmc_noe, fsmc_nwe});
      exp_q.push_back(32'hFFFF); chk("rst_mid_doen", 0, {16'b0, fsmc_doen});
      exp_q.push_back(0);        chk("rst_mid_do", 0, {16'b0, fsmc_do});
      exp_q.push_back(0);        chk("rst_mid_a", 0, {6'b0, fsmc_a});
      exp_q.push_back(32'h3);    chk("rst_mid_nbl", 0, {30'b0, fsmc_nbl});
      for (int k = 0; k < 12; k++) begin
        if (ack) acks++;
        @(negedge hclk);
      end
      exp_q.push_back(0); chk("rst_mid_no_ack", 0, acks);
      exp_q.push_back(0); chk("rst_mid_idle", 0, {31'b0, busy});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

endmodule
